// File: rtl/mem_port_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and the memory-access
// controller (MA). MA normally wins; a starvation counter forces a fetch through
// after STARVE_MAX consecutive MA wins, and a lock holds the port on MA for the
// second beat of a split access. Read data returns one cycle after the grant and
// is steered to whichever requester issued the read.
module mem_port_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ma_req,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  input  logic [3:0]  ma_we,
  input  logic        ma_lock,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [31:0] ma_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_MA   = 2'd2
  } rd_tag_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       lock_q;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  rd_tag_e    rd_tag_q;
  rd_tag_e    rd_tag_d;

  // Grant selection: lock, then starvation override, then MA priority, then IF.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    if_gnt = 1'b0;
    ma_gnt = 1'b0;
    if (!rst_n) begin
      if_gnt = 1'b0;
      ma_gnt = 1'b0;
    end else if (lock_q) begin
      ma_gnt = ma_req;
    end else if (if_req && ma_req && (starve_q == STARVE_LIM)) begin
      if_gnt = 1'b1;
    end else if (ma_req) begin
      ma_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

  assign mem_en = if_gnt | ma_gnt;

  // Drive the memory port from the granted requester; fetches never write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (ma_gnt) begin
      mem_addr  = {ma_addr[31:2], 2'b00};
      mem_wdata = ma_wdata;
      mem_we    = ma_we;
    end else if (if_gnt) begin
      mem_addr  = {if_addr[31:2], 2'b00};
    end
  end

  // Next starvation count: saturating count of MA wins while IF waits.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (ma_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Tag the outstanding read so the return can be routed to its owner.
  always_comb begin
    rd_tag_d = TAG_NONE;
    if (if_gnt) begin
      rd_tag_d = TAG_IF;
    end else if (ma_gnt && (ma_we == 4'b0000)) begin
      rd_tag_d = TAG_MA;
    end
  end

  // Arbitration state; reset drops any pending return, lock and starvation history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q   <= 1'b0;
      starve_q <= '0;
      rd_tag_q <= TAG_NONE;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      lock_q   <= ma_gnt & ma_lock;
      starve_q <= starve_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  // Read return: one cycle after the grant, only the owner sees data.
  assign if_rvalid = (rd_tag_q == TAG_IF);
  assign ma_rvalid = (rd_tag_q == TAG_MA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ma_rdata  = ma_rvalid ? mem_rdata : '0;

endmodule
